// File: rtl/delay_line_ctrl.sv
// -----------------------------------------------------------------------------
// delay_line_ctrl
//
// Sequencing controller for a cascade of KERNEL-1 BRAM line delays in a
// streaming video filter. The first frame after reset is spent measuring the
// active line length. After that the controller:
//   - drives h_size, dl_ce and dl_rst to the delay lines,
//   - tracks the column and row of each pixel,
//   - flags pixels that have a full KERNEL x KERNEL context window,
//   - flags any line whose length differs from the measured one.
//
// Ports:
//   clk           pixel clock; all logic uses the rising edge
//   rst           asynchronous, active-low reset
//   de            data enable of the incoming pixel stream
//   vsync         vertical sync; a rising edge marks frame start
//   dl_ce         clock enable to all delay lines
//   dl_rst        synchronous reset to all delay lines (qualified by dl_ce)
//   h_size        measured line length
//   h_size_valid  h_size has been measured
//   col           column index of the current pixel
//   row           row index of the current line within the frame
//   win_valid     current pixel has a full KERNEL x KERNEL context
//   line_err      sticky line-length mismatch, cleared at frame start
//   state         FSM state: 0 IDLE, 1 MEASURE, 2 WAIT, 3 RUN
//
// All outputs are registered; in RUN they follow de by one cycle.
// -----------------------------------------------------------------------------
module delay_line_ctrl #(
  parameter int BRAM_SIZE_W = 11,
  parameter int ROW_W       = 11,
  parameter int KERNEL      = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   de,
  input  logic                   vsync,
  output logic                   dl_ce,
  output logic                   dl_rst,
  output logic [BRAM_SIZE_W-1:0] h_size,
  output logic                   h_size_valid,
  output logic [BRAM_SIZE_W-1:0] col,
  output logic [ROW_W-1:0]       row,
  output logic                   win_valid,
  output logic                   line_err,
  output logic [1:0]             state
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] MEASURE = 2'd1;
  localparam logic [1:0] WAIT    = 2'd2;
  localparam logic [1:0] RUN     = 2'd3;

  localparam logic [BRAM_SIZE_W-1:0] H_MAX   = {BRAM_SIZE_W{1'b1}};
  localparam logic [ROW_W-1:0]       ROW_MAX = {ROW_W{1'b1}};
  localparam logic [BRAM_SIZE_W-1:0] COL_K   = BRAM_SIZE_W'(KERNEL - 1);
  localparam logic [ROW_W-1:0]       ROW_K   = ROW_W'(KERNEL - 1);

  logic [1:0]             state_reg;
  logic                   de_q_reg;
  logic                   vsync_q_reg;
  logic [BRAM_SIZE_W-1:0] cnt_reg;        // pixels seen in the current line
  logic                   over_reg;       // current line ran past h_size
  logic [BRAM_SIZE_W-1:0] h_size_reg;
  logic                   h_size_valid_reg;
  logic [BRAM_SIZE_W-1:0] col_reg;
  logic [ROW_W-1:0]       row_reg;
  logic                   dl_ce_reg;
  logic                   dl_rst_reg;
  logic                   win_valid_reg;
  logic                   line_err_reg;

  logic                   vs_rise;
  logic                   de_fall;
  logic                   line_seen;
  logic [BRAM_SIZE_W-1:0] col_next;
  logic                   win_next;

  always_comb begin
    vs_rise   = vsync & ~vsync_q_reg;
    de_fall   = ~de & de_q_reg;
    // A pixel dropped by a coincident vs_rise was never counted, so its
    // falling edge must not advance the row or trigger a length check.
    line_seen = (cnt_reg != '0) | over_reg;
    // Long lines pin the column at the last valid delay-line address.
    col_next  = (cnt_reg < h_size_reg) ? cnt_reg : (h_size_reg - 1'b1);
    win_next  = de & (row_reg >= ROW_K) & (col_next >= COL_K);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg        <= IDLE;
      de_q_reg         <= 1'b0;
      vsync_q_reg      <= 1'b0;
      cnt_reg          <= '0;
      over_reg         <= 1'b0;
      h_size_reg       <= '0;
      h_size_valid_reg <= 1'b0;
      col_reg          <= '0;
      row_reg          <= '0;
      dl_ce_reg        <= 1'b0;
      dl_rst_reg       <= 1'b0;
      win_valid_reg    <= 1'b0;
      line_err_reg     <= 1'b0;
    end else begin
      de_q_reg      <= de;
      vsync_q_reg   <= vsync;
      dl_rst_reg    <= 1'b0;
      dl_ce_reg     <= 1'b0;
      win_valid_reg <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (vs_rise) begin
            state_reg <= MEASURE;
            cnt_reg   <= '0;
          end
        end

        MEASURE: begin
          if (de) begin
            // Counter saturates; a pixel beyond the maximum is an overflow.
            if (cnt_reg == H_MAX) begin
              line_err_reg <= 1'b1;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end else if (de_fall && (cnt_reg != '0)) begin
            h_size_reg       <= cnt_reg;
            h_size_valid_reg <= 1'b1;
            cnt_reg          <= '0;
            state_reg        <= WAIT;
          end
        end

        default: begin  // WAIT and RUN
          if (vs_rise) begin
            // Frame start: reset pulse is qualified by dl_ce so the delay
            // lines actually see it. A coincident pixel is dropped.
            state_reg    <= RUN;
            dl_rst_reg   <= 1'b1;
            dl_ce_reg    <= 1'b1;
            row_reg      <= '0;
            col_reg      <= '0;
            cnt_reg      <= '0;
            over_reg     <= 1'b0;
            line_err_reg <= 1'b0;
          end else if (state_reg == RUN) begin
            dl_ce_reg <= de;
            if (de) begin
              col_reg       <= col_next;
              win_valid_reg <= win_next;
              if (cnt_reg == h_size_reg) begin
                over_reg <= 1'b1;
              end else begin
                cnt_reg <= cnt_reg + 1'b1;
              end
            end else if (de_fall && line_seen) begin
              col_reg  <= '0;
              cnt_reg  <= '0;
              over_reg <= 1'b0;
              if (over_reg || (cnt_reg != h_size_reg)) begin
                line_err_reg <= 1'b1;
              end
              if (row_reg != ROW_MAX) begin
                row_reg <= row_reg + 1'b1;
              end
            end
          end
        end
      endcase
    end
  end

  assign state        = state_reg;
  assign dl_ce        = dl_ce_reg;
  assign dl_rst       = dl_rst_reg;
  assign h_size       = h_size_reg;
  assign h_size_valid = h_size_valid_reg;
  assign col          = col_reg;
  assign row          = row_reg;
  assign win_valid    = win_valid_reg;
  assign line_err     = line_err_reg;

endmodule

// File: tb/tb_delay_line_ctrl.sv
// -----------------------------------------------------------------------------
// tb_delay_line_ctrl
//
// Two instances: a small one (BRAM_SIZE_W=4, ROW_W=4) driven from a table of
// per-cycle vectors with a 5-pixel line, then an overflow measurement; and a
// full-size one (BRAM_SIZE_W=11) exercised with 640-pixel lines by
// hand-written sequences.
// -----------------------------------------------------------------------------
module tb_delay_line_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // small instance
  logic       s_rst, s_de, s_vs;
  logic       s_dl_ce, s_dl_rst, s_hv, s_wv, s_le;
  logic [3:0] s_h_size, s_col, s_row;
  logic [1:0] s_state;

  // full-size instance
  logic        b_rst, b_de, b_vs;
  logic        b_dl_ce, b_dl_rst, b_hv, b_wv, b_le;
  logic [10:0] b_h_size, b_col, b_row;
  logic [1:0]  b_state;

  delay_line_ctrl #(.BRAM_SIZE_W(4), .ROW_W(4), .KERNEL(3)) u_small (
    .clk(clk), .rst(s_rst), .de(s_de), .vsync(s_vs),
    .dl_ce(s_dl_ce), .dl_rst(s_dl_rst), .h_size(s_h_size),
    .h_size_valid(s_hv), .col(s_col), .row(s_row),
    .win_valid(s_wv), .line_err(s_le), .state(s_state)
  );

  delay_line_ctrl #(.BRAM_SIZE_W(11), .ROW_W(11), .KERNEL(3)) u_big (
    .clk(clk), .rst(b_rst), .de(b_de), .vsync(b_vs),
    .dl_ce(b_dl_ce), .dl_rst(b_dl_rst), .h_size(b_h_size),
    .h_size_valid(b_hv), .col(b_col), .row(b_row),
    .win_valid(b_wv), .line_err(b_le), .state(b_state)
  );

  typedef struct {
    logic       de;
    logic       vs;
    logic [1:0] st;
    logic       hv;
    logic       ce;
    logic       dr;
    logic [3:0] col;
    logic [3:0] row;
    logic       wv;
    logic       le;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic de, input logic vs, input logic [1:0] st,
                     input logic hv, input logic ce, input logic dr,
                     input int col, input int row, input logic wv, input logic le);
    vec_t v;
    v.de = de; v.vs = vs; v.st = st; v.hv = hv; v.ce = ce; v.dr = dr;
    v.col = 4'(col); v.row = 4'(row); v.wv = wv; v.le = le;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // advance one clock; outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one 640-class line on the big instance; counts win_valid cycles
  task automatic big_line(input int n, output int wv_cnt,
                          output int first_row, output int first_col);
    wv_cnt = 0; first_row = -1; first_col = -1;
    for (int i = 0; i < n; i++) begin
      b_de = 1'b1;
      tick();
      if (b_wv) begin
        if (wv_cnt == 0) begin
          first_row = int'(b_row);
          first_col = int'(b_col);
        end
        wv_cnt++;
      end
    end
    b_de = 1'b0;
    tick();
    tick();
    tick();
  endtask

  initial begin
    int   wv_cnt, fr, fc, ce_seen, wv_seen;
    logic [17:0] act, exp;

    s_rst = 1'b0; s_de = 1'b0; s_vs = 1'b0;
    b_rst = 1'b0; b_de = 1'b0; b_vs = 1'b0;
    tick();
    tick();

    // ---- reset state ----
    chk("reset_state", int'(b_state), 0);
    chk("reset_outs", int'({b_dl_ce, b_dl_rst, b_hv, b_wv, b_le}), 0);
    chk("reset_h_size", int'(b_h_size), 0);
    s_rst = 1'b1;
    b_rst = 1'b1;

    // ---- table-driven run on the small instance (line length 5) ----
    add(0,1, 1,0,0,0, 0,0,0,0);
    add(0,0, 1,0,0,0, 0,0,0,0);
    for (int c = 0; c < 5; c++) add(1,0, 1,0,0,0, 0,0,0,0);
    add(0,0, 2,1,0,0, 0,0,0,0);                  // h_size latched
    add(0,1, 3,1,1,1, 0,0,0,0);                  // frame start pulse
    add(0,0, 3,1,0,0, 0,0,0,0);
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 5; c++) add(1,0, 3,1,1,0, c,r, (r >= 2 && c >= 2),0);
      add(0,0, 3,1,0,0, 0,r+1,0,0);
    end
    for (int c = 0; c < 4; c++) add(1,0, 3,1,1,0, c,3, (c >= 2),0);  // short line
    add(0,0, 3,1,0,0, 0,4,0,1);
    add(0,0, 3,1,0,0, 0,4,0,1);                  // error is sticky
    add(0,1, 3,1,1,1, 0,0,0,0);                  // cleared at frame start
    add(0,0, 3,1,0,0, 0,0,0,0);
    for (int c = 0; c < 7; c++) add(1,0, 3,1,1,0, (c < 4 ? c : 4),0,0,0);  // long line
    add(0,0, 3,1,0,0, 0,1,0,1);

    for (int i = 0; i < tbl.size(); i++) begin
      s_de = tbl[i].de;
      s_vs = tbl[i].vs;
      tick();
      act = {s_state, s_hv, s_dl_ce, s_dl_rst, s_col, s_row, s_wv, s_le, 3'b000};
      exp = {tbl[i].st, tbl[i].hv, tbl[i].ce, tbl[i].dr, tbl[i].col, tbl[i].row,
             tbl[i].wv, tbl[i].le, 3'b000};
      checks++;
      if (act != exp) begin
        failures++;
        $display("FAIL vec%0d {st,hv,ce,rst,col,row,wv,le}: got %h expected %h", i, act, exp);
      end
    end
    chk("small_h_size", int'(s_h_size), 5);

    // ---- small instance: 20-pixel measurement saturates at 15 ----
    s_de = 1'b0; s_vs = 1'b0;
    s_rst = 1'b0;
    tick();
    s_rst = 1'b1;
    s_vs = 1'b1; tick(); s_vs = 1'b0; tick();
    for (int i = 0; i < 20; i++) begin s_de = 1'b1; tick(); end
    s_de = 1'b0; tick();
    chk("ovf_h_size", int'(s_h_size), 15);
    chk("ovf_line_err", int'(s_le), 1);
    chk("ovf_state", int'(s_state), 2);

    // ---- big: measure 640 ----
    b_vs = 1'b1; tick(); b_vs = 1'b0; tick();
    chk("meas_state", int'(b_state), 1);
    ce_seen = 0; wv_seen = 0;
    for (int i = 0; i < 640; i++) begin
      b_de = 1'b1; tick();
      ce_seen += int'(b_dl_ce);
      wv_seen += int'(b_wv);
    end
    chk("meas_hv_early", int'(b_hv), 0);
    b_de = 1'b0; tick();
    chk("meas_h_size", int'(b_h_size), 640);
    chk("meas_hv", int'(b_hv), 1);
    chk("meas_wait", int'(b_state), 2);
    chk("meas_no_ce", ce_seen, 0);
    chk("meas_no_wv", wv_seen, 0);
    tick();

    // ---- big: 4-line frame ----
    b_vs = 1'b1; tick();
    chk("fs_dl_rst", int'(b_dl_rst), 1);
    chk("fs_dl_ce", int'(b_dl_ce), 1);
    chk("fs_run", int'(b_state), 3);
    b_vs = 1'b0; tick();
    chk("fs_dl_rst_end", int'(b_dl_rst), 0);
    for (int r = 0; r < 4; r++) begin
      big_line(640, wv_cnt, fr, fc);
      chk($sformatf("wv_count_row%0d", r), wv_cnt, (r >= 2) ? 638 : 0);
      if (r == 2) begin
        chk("first_wv_row", fr, 2);
        chk("first_wv_col", fc, 2);
      end
    end
    chk("frame_rows", int'(b_row), 4);
    chk("frame_no_err", int'(b_le), 0);

    // ---- big: short line 1 ----
    b_vs = 1'b1; tick(); b_vs = 1'b0; tick();
    big_line(640, wv_cnt, fr, fc);
    chk("err_line0", int'(b_le), 0);
    big_line(639, wv_cnt, fr, fc);
    chk("err_line1", int'(b_le), 1);
    big_line(640, wv_cnt, fr, fc);
    chk("err_sticky", int'(b_le), 1);
    b_vs = 1'b1; tick();
    chk("err_cleared", int'(b_le), 0);
    b_vs = 1'b0; tick();

    // ---- big: de coincident with vs_rise ----
    big_line(640, wv_cnt, fr, fc);
    chk("pre_row", int'(b_row), 1);
    b_vs = 1'b1; b_de = 1'b1; tick();
    chk("coin_dl_rst", int'(b_dl_rst), 1);
    chk("coin_col", int'(b_col), 0);
    chk("coin_row", int'(b_row), 0);
    chk("coin_wv", int'(b_wv), 0);
    b_vs = 1'b0; b_de = 1'b0; tick();
    chk("coin_row_after", int'(b_row), 0);
    chk("coin_no_err", int'(b_le), 0);

    // ---- big: reset mid-line ----
    for (int i = 0; i < 100; i++) begin b_de = 1'b1; tick(); end
    chk("pre_rst_ce", int'(b_dl_ce), 1);
    b_rst = 1'b0;
    #1;
    chk("async_outs", int'({b_dl_ce, b_dl_rst, b_hv, b_wv, b_le}), 0);
    chk("async_cnt", int'({b_col, b_row, b_h_size}), 0);
    chk("async_state", int'(b_state), 0);
    tick();
    b_rst = 1'b1;
    for (int i = 0; i < 50; i++) tick();
    b_de = 1'b0; tick(); tick();
    chk("post_rst_idle", int'(b_state), 0);
    b_vs = 1'b1; tick(); b_vs = 1'b0; tick();
    for (int i = 0; i < 320; i++) begin b_de = 1'b1; tick(); end
    b_de = 1'b0; tick();
    chk("remeas_h_size", int'(b_h_size), 320);
    chk("remeas_state", int'(b_state), 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/delay_line_ctrl.md
Name: delay_line_ctrl

Overview:
- Sequencing controller for a stack of BRAM line delays (KERNEL-1 delay lines in cascade) in the streaming video filter pipeline.
- Detects frame start and measures the active line length on the first frame after reset. Supplies h_size, clock-enable and reset to the delay lines.
- Tracks column and row positions and flags when a full KERNEL x KERNEL context window is valid.
- Monitors every subsequent line for a length mismatch.

Parameters:
- BRAM_SIZE_W, 11, width of the line-length and column counters (max line 2^BRAM_SIZE_W-1 pixels).
- ROW_W, 11, width of the row counter.
- KERNEL, 3, context window size; rows and columns required before win_valid.

Ports:
- clk  input  1  pixel clock, all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- de  input  1  data enable of incoming pixel stream.
- vsync  input  1  vertical sync; rising edge marks frame start.
- dl_ce  output  1  clock enable to all delay lines.
- dl_rst  output  1  reset to all delay lines (sync, active-high, sampled only with dl_ce).
- h_size  output  BRAM_SIZE_W  measured line length driven to delay lines.
- h_size_valid  output  1  h_size has been measured.
- col  output  BRAM_SIZE_W  column index of current pixel.
- row  output  ROW_W  row index of current line in frame.
- win_valid  output  1  current pixel has full KERNEL x KERNEL context.
- line_err  output  1  sticky line-length mismatch flag, cleared at frame start.
- state  output  2  current FSM state: 0 IDLE, 1 MEASURE, 2 WAIT, 3 RUN.

Behaviour:
- Reset (rst=0, async): state=IDLE; all outputs 0; h_size=0; internal de/vsync edge registers cleared.
- Edge detection:
  - de and vsync are registered once.
  - vs_rise = vsync & ~vsync_q.
  - de_fall = ~de & de_q.
- FSM:
  - IDLE -> MEASURE on vs_rise.
  - MEASURE: counter increments on each de=1 cycle. On de_fall, latch h_size=count, set h_size_valid=1, go to WAIT.
  - WAIT -> RUN on the next vs_rise.
  - RUN -> RUN on each vs_rise; never returns to IDLE except by reset.
  - The first frame after reset is used only for measurement; its pixels never assert win_valid.
- Measure overflow: if the count reaches 2^BRAM_SIZE_W-1 while de=1, saturate, latch the saturated value, and set line_err=1.
- Frame start (any vs_rise in WAIT or RUN):
  - dl_rst=1 and dl_ce=1 together for exactly one cycle, so the delay lines honour the reset.
  - row=0, col=0, line_err=0.
  - If de=1 coincides with vs_rise, the vs_rise frame-start action wins and that pixel is dropped.
- RUN datapath: all outputs are registered, latency 1 cycle from de.
  - dl_ce = de_q.
  - col increments per de cycle and returns to 0 after de_fall.
  - row increments on de_fall and saturates at 2^ROW_W-1.
- Line check in RUN: on de_fall, if the line's pixel count != h_size, set line_err=1 (sticky until next vs_rise).
  - Short lines do not resynchronise the delay lines.
  - Long lines: col saturates at h_size-1.
- win_valid = de_q & (row >= KERNEL-1) & (col >= KERNEL-1) & (state==RUN).
- Outside RUN: dl_ce=0, win_valid=0.
- h_size is constant after measurement and changes only after a reset plus a new measurement.
- Mid-frame reset: all outputs drop immediately. After release the controller re-measures, ignoring the remainder of the current frame until the next vs_rise.

Test Plan:
- Reset, vsync pulse, one 640-pixel de line -> h_size=640, h_size_valid=1 one cycle after de_fall, state=WAIT, dl_ce stayed 0.
- Measured 640; second frame of 4 lines x 640 -> dl_rst=dl_ce=1 for one cycle at vs_rise; win_valid first high at row=2, col=2; 638 win_valid cycles per line on rows 2-3.
- RUN frame with line 1 of 639 pixels -> line_err=1 after that de_fall, remains 1 through frame, cleared at next vs_rise.
- BRAM_SIZE_W=4, measure line of 20 pixels -> h_size=15, line_err=1.
- de=1 coinciding with vs_rise in RUN -> pixel dropped, col=0, row=0, dl_rst pulse present.
- Assert rst=0 mid-line in RUN -> all outputs 0 same cycle (async); after release, state=IDLE, next frame re-measures.
